// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the round-robin / fixed-select stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    // Index width for n channels; never below 1 so a 2-channel mux still has a select bit.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last granted
// channel, with wrap-around for any channel count.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                upd,
    output logic [CHANNELS-1:0] grant
);

    localparam int SEL_W = sel_width(CHANNELS);

    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] gidx;
    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            if (int'(last) + i >= CHANNELS)
                idx = SEL_W'(int'(last) + i - CHANNELS);
            else
                idx = SEL_W'(int'(last) + i);
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gidx        = idx;
            end
        end
    end

    // Pointer only moves on a real transfer, so stalls never cost a channel its turn.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= SEL_W'(CHANNELS - 1);
        else if (upd)
            last <= gidx;
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with fixed-select or round-robin arbitration and a
// single registered output slot (1-cycle latency, full throughput).
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    if (SEL_W != sel_width(CHANNELS) || CHANNELS < 2 || CHANNELS > 16) begin : g_param_check
        $error("stream_mux_rr: CHANNELS must be 2..16 and SEL_W must equal max(1, clog2(CHANNELS))");
    end

    slot_e               state_p1, state_d;
    logic [WIDTH-1:0]    data_p1;
    logic [SEL_W-1:0]    chan_p1;

    logic                load_en;
    logic                accept;
    logic                upd;
    logic [CHANNELS-1:0] rr_grant;
    logic [CHANNELS-1:0] fix_grant;
    logic [CHANNELS-1:0] grant;
    logic [WIDTH-1:0]    mux_data;
    logic [SEL_W-1:0]    mux_chan;

    rr_arbiter #(
        .CHANNELS(CHANNELS)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (in_valid),
        .upd  (upd),
        .grant(rr_grant)
    );

    // Out-of-range select (possible when CHANNELS is not a power of two) grants nobody.
    always_comb begin
        fix_grant = '0;
        if (int'(sel) < CHANNELS)
            fix_grant[sel] = 1'b1;
    end

    assign load_en  = (state_p1 == SLOT_EMPTY) || out_ready;
    assign grant    = (mode == MODE_RR) ? rr_grant : fix_grant;
    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign accept   = |(in_valid & in_ready);
    assign upd      = accept && (mode == MODE_RR);

    always_comb begin
        mux_data = '0;
        mux_chan = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant[k]) begin
                mux_data = in_data[k*WIDTH +: WIDTH];
                mux_chan = SEL_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_p1;
        if (load_en)
            state_d = accept ? SLOT_FULL : SLOT_EMPTY;
    end

    // Stage p1: output slot register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p1 <= SLOT_EMPTY;
            data_p1  <= '0;
            chan_p1  <= '0;
        end else begin
            state_p1 <= state_d;
            if (accept) begin
                data_p1 <= mux_data;
                chan_p1 <= mux_chan;
            end
        end
    end

    assign out_valid = (state_p1 == SLOT_FULL);
    assign out_data  = data_p1;
    assign out_chan  = chan_p1;

endmodule
